// File: rtl/pwm_demod.sv
// PWM-to-PCM demodulator: counts high samples over a free-running 2^C_frame_bits frame aligned to the first rise.
// Optional macro PWM_DEMOD_AVG_EN averages each frame with the previous one before output.
module pwm_demod #(
    parameter int C_frame_bits = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pwm_in,
    output logic [C_frame_bits-1:0] pcm,
    output logic                    pcm_valid,
    output logic                    locked,
    output logic                    stuck
);

    localparam int W = C_frame_bits;
    localparam logic [W-1:0] FRAME_LAST = '1;

    typedef enum logic {
        ST_ALIGN,
        ST_MEASURE
    } state_e;

    // Synchronizer and edge-detect flops.
    logic sync1_q;
    logic s_q;
    logic s_d_q;
    logic rise_det;
    logic edge_det;

    state_e       state_q;
    logic [W-1:0] fcnt_q;
    logic [W:0]   hcnt_q;
    logic         edge_seen_q;
    logic [W-1:0] pcm_q;
    logic         pcm_valid_q;
    logic         locked_q;
    logic         stuck_q;

    logic [W:0]   total;
    logic [W-1:0] sat;
    logic [W-1:0] pcm_d;

`ifdef PWM_DEMOD_AVG_EN
    logic [W-1:0] sat_prev_q;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            s_q     <= 1'b0;
            s_d_q   <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            s_q     <= sync1_q;
            s_d_q   <= s_q;
        end
    end

    assign rise_det = s_q & ~s_d_q;
    assign edge_det = s_q ^ s_d_q;

    // Frame total includes the current sample; a full-high frame saturates to all ones.
    always_comb begin
        total = hcnt_q + (W + 1)'(s_q);
        sat   = total[W] ? '1 : total[W-1:0];
`ifdef PWM_DEMOD_AVG_EN
        pcm_d = W'(({1'b0, sat} + {1'b0, sat_prev_q}) >> 1);
`else
        pcm_d = sat;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ALIGN;
            fcnt_q      <= '0;
            hcnt_q      <= '0;
            edge_seen_q <= 1'b0;
            pcm_q       <= '0;
            pcm_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            stuck_q     <= 1'b0;
`ifdef PWM_DEMOD_AVG_EN
            sat_prev_q  <= '0;
`endif
        end else begin
            pcm_valid_q <= 1'b0;
            case (state_q)
                ST_ALIGN: begin
                    fcnt_q      <= '0;
                    hcnt_q      <= '0;
                    edge_seen_q <= 1'b0;
                    // The aligning rise is frame cycle 0 and its high sample is already counted.
                    if (rise_det) begin
                        state_q     <= ST_MEASURE;
                        fcnt_q      <= W'(1);
                        hcnt_q      <= (W + 1)'(1);
                        edge_seen_q <= 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (fcnt_q == FRAME_LAST) begin
                        pcm_q       <= pcm_d;
                        pcm_valid_q <= 1'b1;
                        locked_q    <= 1'b1;
                        stuck_q     <= ~(edge_seen_q | edge_det);
                        hcnt_q      <= '0;
                        fcnt_q      <= '0;
                        edge_seen_q <= 1'b0;
`ifdef PWM_DEMOD_AVG_EN
                        sat_prev_q  <= sat;
`endif
                    end else begin
                        hcnt_q      <= total;
                        fcnt_q      <= fcnt_q + W'(1);
                        edge_seen_q <= edge_seen_q | edge_det;
                    end
                end
                default: state_q <= ST_ALIGN;
            endcase
        end
    end

    assign pcm       = pcm_q;
    assign pcm_valid = pcm_valid_q;
    assign locked    = locked_q;
    assign stuck     = stuck_q;

endmodule
